// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-master RAM port arbiter.
// Master IDs double as bit positions in the 2-bit request/exclude vectors.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

  localparam logic M_IF = 1'b0;
  localparam logic M_D  = 1'b1;

  // One-hot mask for a master ID, used to exclude the master just acked.
  function automatic logic [1:0] master_mask(input logic m);
    return (m == M_D) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-input round-robin picker: on a tie the master not granted last wins;
// requests masked by excl never win.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic [1:0] excl,
  output logic       grant,
  output logic       valid
);

  logic [1:0] eff;

  assign eff   = req & ~excl;
  assign valid = |eff;

  always_comb begin
    grant = M_IF;
    if (eff == 2'b11) begin
      grant = ~last_grant;
    end else if (eff[M_D]) begin
      grant = M_D;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates the instruction-fetch and load/store ports onto one single-port
// RAM, one transaction in flight, registered RAM controls, one-cycle acks.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WHITH = 30,
  parameter int DATA_WHITH = 32,
  parameter int DATA_BYTE  = DATA_WHITH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WHITH-1:0] if_addr,
  output logic                  if_ack,
  output logic [DATA_WHITH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic [DATA_BYTE-1:0]  d_we,
  input  logic [ADDR_WHITH-1:0] d_addr,
  input  logic [DATA_WHITH-1:0] d_wdata,
  output logic                  d_ack,
  output logic [DATA_WHITH-1:0] d_rdata,
  output logic                  ram_cs,
  output logic [DATA_BYTE-1:0]  ram_we,
  output logic [ADDR_WHITH-1:0] ram_addr,
  output logic [DATA_WHITH-1:0] ram_wdata,
  input  logic [DATA_WHITH-1:0] ram_rdata,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  // Handshake: a master raises req with stable addr/we/wdata and holds it
  // until it sees its one-cycle ack; rdata is meaningful only during ack.
  // Requests are sampled only in IDLE and RESP, the only grant points.

  arb_state_t            state_q, state_d;
  logic                  last_grant, grant_d;
  logic                  cs_d;
  logic [DATA_BYTE-1:0]  we_d;
  logic [ADDR_WHITH-1:0] addr_d;
  logic [DATA_WHITH-1:0] wdata_d;
  logic [1:0]            excl;
  logic                  arb_grant, arb_valid;
  logic                  take;
  logic [DATA_WHITH-1:0] resp_data;

  // While responding, the acked master's req is still high; keep it out.
  assign excl = (state_q == ST_RESP) ? master_mask(last_grant) : 2'b00;

  rr_arb2 u_rr_arb2 (
    .req        ({d_req, if_req}),
    .last_grant (last_grant),
    .excl       (excl),
    .grant      (arb_grant),
    .valid      (arb_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      last_grant <= M_IF;
      ram_cs     <= 1'b0;
      ram_we     <= '0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
    end else begin
      state_q    <= state_d;
      last_grant <= grant_d;
      ram_cs     <= cs_d;
      ram_we     <= we_d;
      ram_addr   <= addr_d;
      ram_wdata  <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = last_grant;
    cs_d    = 1'b0;
    we_d    = ram_we;
    addr_d  = ram_addr;
    wdata_d = ram_wdata;
    take    = 1'b0;
    case (state_q)
      ST_IDLE:   take = arb_valid;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP: begin
        take = arb_valid;
        if (!arb_valid) state_d = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
    if (take) begin
      state_d = ST_ACCESS;
      cs_d    = 1'b1;
      grant_d = arb_grant;
      if (arb_grant == M_D) begin
        we_d    = d_we;
        addr_d  = d_addr;
        wdata_d = d_wdata;
      end else begin
        we_d    = '0;
        addr_d  = if_addr;
        wdata_d = '0;
      end
    end
  end

  // ram_we is held through RESP, so it still tells a write from a read.
  assign resp_data = (|ram_we) ? '0 : ram_rdata;

  assign if_ack    = (state_q == ST_RESP) && (last_grant == M_IF);
  assign d_ack     = (state_q == ST_RESP) && (last_grant == M_D);
  assign if_rdata  = if_ack ? resp_data : '0;
  assign d_rdata   = d_ack ? resp_data : '0;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: two master agents, a RAM model, and a monitor
// that checks every ack against an expected queue filled at issue time.
module tb_ram_port_arbiter;

  localparam int AW = 30;
  localparam int DW = 32;
  localparam int DB = DW / 8;
  localparam int EW = 8 + 1 + DW;  // {gap, master, data}

  logic          clk;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic [DB-1:0] d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          ram_cs;
  logic [DB-1:0] ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          busy;
  logic [1:0]    dbg_state;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DB-1:0] we;
    logic [DW-1:0] wdata;
  } cmd_t;

  cmd_t          if_cmd_q[$];
  cmd_t          d_cmd_q[$];
  logic [EW-1:0] exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_ack = 0;

  ram_port_arbiter #(.ADDR_WHITH(AW), .DATA_WHITH(DW), .DATA_BYTE(DB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .ram_cs    (ram_cs),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model: word-indexed, byte-lane write mask, read data one cycle after cs
  logic [DW-1:0] mem [0:255];
  bit preload_done = 1'b0;
  always @(posedge clk) begin
    if (!preload_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem[0]       <= 32'h3C011234;
      mem[3]       <= 32'h0C000010;
      mem[4]       <= 32'h24420001;
      ram_rdata    <= '0;
      preload_done <= 1'b1;
    end else if (ram_cs) begin
      for (int i = 0; i < DB; i++)
        if (ram_we[i]) mem[ram_addr[9:2]][8*i +: 8] <= ram_wdata[8*i +: 8];
      ram_rdata <= mem[ram_addr[9:2]];
    end
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic m, input logic [DW-1:0] data, input int gap);
    exp_q.push_back({gap[7:0], m, data});
  endtask

  task automatic issue_if(input logic [AW-1:0] addr, input logic [DW-1:0] exp, input int gap);
    cmd_t c;
    c.addr = addr; c.we = '0; c.wdata = '0;
    if_cmd_q.push_back(c);
    push_exp(1'b0, exp, gap);
  endtask

  task automatic issue_d(input logic [DB-1:0] we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [DW-1:0] exp, input int gap);
    cmd_t c;
    c.addr = addr; c.we = we; c.wdata = wdata;
    d_cmd_q.push_back(c);
    push_exp(1'b1, exp, gap);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (if_cmd_q.size() == 0 && d_cmd_q.size() == 0 && !if_req && !d_req &&
          !busy && exp_q.size() == 0) begin
        @(posedge clk);
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL idle_timeout: got busy=%0b pending=%0d expected idle (t=%0t)", busy, exp_q.size(), $time);
    @(posedge clk);
  endtask

  // Waits for the edge at which the given master's request is first sampled.
  task automatic wait_req_edge(input logic is_d, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      if (is_d ? d_req : if_req) begin
        ok = 1'b1;
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL req_timeout: got no request expected request within 20 cycles");
  endtask

  // Fetch master agent
  initial begin
    cmd_t c;
    if_req  = 1'b0;
    if_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        if_req = 1'b0;
      end else if (if_req) begin
        if (if_ack) if_req = 1'b0;
      end else if (if_cmd_q.size() > 0) begin
        c = if_cmd_q.pop_front();
        if_addr = c.addr;
        if_req  = 1'b1;
      end
    end
  end

  // Data master agent
  initial begin
    cmd_t c;
    d_req   = 1'b0;
    d_we    = '0;
    d_addr  = '0;
    d_wdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        d_req = 1'b0;
      end else if (d_req) begin
        if (d_ack) d_req = 1'b0;
      end else if (d_cmd_q.size() > 0) begin
        c = d_cmd_q.pop_front();
        d_we    = c.we;
        d_addr  = c.addr;
        d_wdata = c.wdata;
        d_req   = 1'b1;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    logic [EW-1:0] e;
    int gap;
    forever begin
      @(negedge clk);
      cyc++;
      if (if_ack || d_ack) begin
        check("ack_exclusive", {31'd0, if_ack & d_ack}, 32'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ack: got if_ack=%0b d_ack=%0b expected no ack (t=%0t)", if_ack, d_ack, $time);
        end else begin
          e = exp_q.pop_front();
          gap = int'(e[EW-1 -: 8]);
          check("ack_master", {31'd0, d_ack}, {31'd0, e[DW]});
          if (d_ack) begin
            check("d_rdata", d_rdata, e[DW-1:0]);
            check("if_rdata_idle", if_rdata, 32'd0);
          end else begin
            check("if_rdata", if_rdata, e[DW-1:0]);
            check("d_rdata_idle", d_rdata, 32'd0);
          end
          if (gap != 0) check("ack_gap", cyc - last_ack, gap);
        end
        last_ack = cyc;
      end
    end
  end

  // Stimulus
  initial begin
    bit ok;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ram_cs", {31'd0, ram_cs}, 32'd0);
    check("rst_ram_we", {28'd0, ram_we}, 32'd0);
    check("rst_ram_addr", {2'd0, ram_addr}, 32'd0);
    check("rst_ram_wdata", ram_wdata, 32'd0);
    check("rst_acks", {30'd0, if_ack, d_ack}, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);

    // Isolated fetch: cs one cycle after request is sampled, ack the next
    issue_if(30'h0, 32'h3C011234, 0);
    wait_req_edge(1'b0, ok);
    if (ok) begin
      @(negedge clk);
      check("t1_cs_high", {31'd0, ram_cs}, 32'd1);
      check("t1_addr", {2'd0, ram_addr}, 32'd0);
      check("t1_we", {28'd0, ram_we}, 32'd0);
      check("t1_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      check("t1_cs_low", {31'd0, ram_cs}, 32'd0);
      check("t1_ack", {31'd0, if_ack}, 32'd1);
    end
    wait_idle(50);

    // Full-word store then load back
    issue_d(4'hF, 30'h100, 32'hDEADBEEF, 32'h0, 0);
    wait_idle(50);
    issue_d(4'h0, 30'h100, 32'h0, 32'hDEADBEEF, 0);
    wait_idle(50);

    // Tie right after reset: data first, fetch two cycles later; next tie data again
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    issue_d(4'h0, 30'h100, 32'h0, 32'hDEADBEEF, 0);
    issue_if(30'h0, 32'h3C011234, 2);
    wait_idle(50);
    issue_d(4'h0, 30'h0, 32'h0, 32'h3C011234, 0);
    issue_if(30'hC, 32'h0C000010, 2);
    wait_idle(50);

    // Byte-lane store touches only lane 0
    issue_d(4'hF, 30'h104, 32'h11223344, 32'h0, 0);
    wait_idle(50);
    issue_d(4'b0001, 30'h104, 32'h000000AA, 32'h0, 0);
    wait_idle(50);
    issue_d(4'h0, 30'h104, 32'h0, 32'h112233AA, 0);
    wait_idle(50);

    // Both masters streaming: fetch wins first (data was last), then strict alternation
    issue_if(30'h0,   32'h3C011234, 0);
    issue_d (4'h0, 30'h10,  32'h0, 32'h24420001, 2);
    issue_if(30'h100, 32'hDEADBEEF, 2);
    issue_d (4'h0, 30'hC,   32'h0, 32'h0C000010, 2);
    issue_if(30'h104, 32'h112233AA, 2);
    issue_d (4'h0, 30'h104, 32'h0, 32'h112233AA, 2);
    issue_if(30'hC,   32'h0C000010, 2);
    issue_d (4'h0, 30'h100, 32'h0, 32'hDEADBEEF, 2);
    issue_if(30'h10,  32'h24420001, 2);
    issue_d (4'h0, 30'h0,   32'h0, 32'h3C011234, 2);
    wait_idle(100);

    // Reset in the middle of ACCESS aborts the store without an ack
    begin
      cmd_t c;
      c.addr = 30'h108; c.we = 4'hF; c.wdata = 32'h55555555;
      d_cmd_q.push_back(c);
    end
    wait_req_edge(1'b1, ok);
    if (ok) begin
      @(negedge clk);
      check("t6_cs_before_rst", {31'd0, ram_cs}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("t6_cs_rst", {31'd0, ram_cs}, 32'd0);
      check("t6_busy_rst", {31'd0, busy}, 32'd0);
      check("t6_ack_rst", {31'd0, d_ack}, 32'd0);
      @(negedge clk);
      check("t6_ack_hold", {31'd0, d_ack}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
    end
    wait_idle(50);
    issue_d(4'h0, 30'h108, 32'h0, 32'h0, 0);
    wait_idle(50);
    issue_d(4'hF, 30'h108, 32'h55555555, 32'h0, 0);
    wait_idle(50);
    issue_d(4'h0, 30'h108, 32'h0, 32'h55555555, 0);
    wait_idle(50);

    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
